bar_flash_sched: RTL and testbench

BAR_FLASH_SCHED -- requirements
Module: bar_flash_sched

---
 rtl/bar_flash_sched.sv | 103 ++++++++++
 tb/tb_bar_flash_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bar_flash_sched.sv
// Per-bar flash scheduler for a VGA xylophone: latches bar hits, grants one
// flash per frame in round-robin order during vblank and decays flash timers.
module bar_flash_sched #(
  parameter int NUM_BARS     = 8,
  parameter int FLASH_FRAMES = 30,
  parameter int V_ACTIVE     = 480
) (
  input  logic                clk_25,
  input  logic                rst,
  input  logic [9:0]          pixel_y,
  input  logic [NUM_BARS-1:0] hit_req,
  output logic [NUM_BARS-1:0] bar_active,
  output logic                grant_pulse,
  output logic [2:0]          grant_id,
  output logic                frame_tick,
  output logic [19:0]         frame_count
);

  localparam int PTR_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  typedef enum logic [1:0] {WAIT_VBL, DECAY, GRANT, WAIT_ACT} state_t;

  state_t              state;
  logic [NUM_BARS-1:0] pending;
  logic [5:0]          timer [NUM_BARS];
  logic [PTR_W-1:0]    rr_ptr;
  logic [19:0]         frame_cnt;

  logic                vblank;
  logic                sel_found;
  logic [PTR_W-1:0]    sel_idx;
  logic [PTR_W-1:0]    rr_next;
  logic [NUM_BARS-1:0] sel_mask;

  assign vblank      = ({22'd0, pixel_y} >= 32'(V_ACTIVE));
  assign frame_count = frame_cnt;

  // Round-robin pick: first pending bar at or above rr_ptr, wrapping to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_BARS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_BARS) idx = idx - NUM_BARS;
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    rr_next  = (int'(sel_idx) == NUM_BARS - 1) ? '0 : sel_idx + 1'b1;
    sel_mask = sel_found ? (NUM_BARS'(1) << sel_idx) : '0;
  end

  always_comb begin
    bar_active = '0;
    for (int i = 0; i < NUM_BARS; i++) bar_active[i] = (timer[i] != 6'd0);
  end

  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_ACT;
      pending     <= '0;
      for (int i = 0; i < NUM_BARS; i++) timer[i] <= 6'd0;
      rr_ptr      <= '0;
      grant_id    <= 3'd0;
      grant_pulse <= 1'b0;
      frame_tick  <= 1'b0;
      frame_cnt   <= 20'd0;
    end else begin
      grant_pulse <= 1'b0;
      frame_tick  <= 1'b0;
      pending     <= pending | hit_req;
      case (state)
        WAIT_VBL: if (vblank) state <= DECAY;
        DECAY: begin
          for (int i = 0; i < NUM_BARS; i++)
            if (timer[i] != 6'd0) timer[i] <= timer[i] - 6'd1;
          frame_tick <= 1'b1;
          frame_cnt  <= frame_cnt + 20'd1;
          state      <= GRANT;
        end
        GRANT: begin
          if (sel_found) begin
            timer[sel_idx] <= 6'(FLASH_FRAMES);
            // A hit landing in this same cycle re-arms the bar just served.
            pending        <= (pending & ~sel_mask) | hit_req;
            grant_id       <= 3'(sel_idx);
            grant_pulse    <= 1'b1;
            rr_ptr         <= rr_next;
          end
          state <= WAIT_ACT;
        end
        WAIT_ACT: if (!vblank) state <= WAIT_VBL;
        default:  state <= WAIT_ACT;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_flash_sched.sv
// Randomized scoreboard bench for bar_flash_sched against a frame-level
// behavioural model of the hit / grant / decay rules.
module tb_bar_flash_sched;

  localparam int NB = 8;
  localparam int FF = 30;
  localparam int VA = 480;

  logic          clk_25 = 1'b0;
  logic          rst;
  logic [9:0]    pixel_y;
  logic [NB-1:0] hit_req;
  logic [NB-1:0] bar_active;
  logic          grant_pulse;
  logic [2:0]    grant_id;
  logic          frame_tick;
  logic [19:0]   frame_count;

  always #20 clk_25 = ~clk_25;

  bar_flash_sched #(.NUM_BARS(NB), .FLASH_FRAMES(FF), .V_ACTIVE(VA)) dut (
    .clk_25(clk_25), .rst(rst), .pixel_y(pixel_y), .hit_req(hit_req),
    .bar_active(bar_active), .grant_pulse(grant_pulse), .grant_id(grant_id),
    .frame_tick(frame_tick), .frame_count(frame_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending set, per-bar flash timers, frame-level schedule.
  logic [NB-1:0] m_pend;
  int            m_timer [NB];
  int            m_rr;
  int            m_gid;
  logic [19:0]   m_fc;
  bit            need_vis;
  int            decay_edge;
  int            grant_edge;
  int            edge_no = 0;

  int          grant_q [$];
  logic [19:0] tick_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] m_active();
    logic [NB-1:0] a;
    a = '0;
    for (int i = 0; i < NB; i++) a[i] = (m_timer[i] > 0);
    return a;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < NB; k++) begin
      int idx;
      idx = (m_rr + k) % NB;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    for (int i = 0; i < NB; i++) m_timer[i] = 0;
    m_rr = 0;
    m_gid = 0;
    m_fc = '0;
    need_vis = 1'b1;
    decay_edge = -1;
    grant_edge = -1;
    grant_q.delete();
    tick_q.delete();
  endtask

  task automatic model_edge(input logic [9:0] py, input logic [NB-1:0] hr);
    logic [NB-1:0] np;
    bit vbl;
    int pk;
    edge_no++;
    vbl = (py >= 10'(VA));
    np = m_pend;
    if (edge_no == decay_edge) begin
      for (int i = 0; i < NB; i++) if (m_timer[i] > 0) m_timer[i]--;
      m_fc = m_fc + 20'd1;
      tick_q.push_back(m_fc);
    end else if (edge_no == grant_edge) begin
      pk = m_pick();
      if (pk >= 0) begin
        m_timer[pk] = FF;
        np[pk] = 1'b0;
        m_gid = pk;
        m_rr = (pk + 1) % NB;
        grant_q.push_back(pk);
      end
    end else if (need_vis) begin
      if (!vbl) need_vis = 1'b0;
    end else if (vbl) begin
      decay_edge = edge_no + 1;
      grant_edge = edge_no + 2;
      need_vis = 1'b1;
    end
    m_pend = np | hr;
  endtask

  // Monitor: pops expected grants/ticks whenever the DUT is sampled.
  always @(negedge clk_25) begin
    if (rst === 1'b1) begin
      int eg;
      logic [19:0] ef;
      chk("bar_active", 32'(bar_active), 32'(m_active()));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("grant_id_hold", 32'(grant_id), 32'(m_gid));
      if (grant_q.size() > 0) begin
        eg = grant_q.pop_front();
        chk("grant_pulse", 32'(grant_pulse), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(eg));
      end else begin
        chk("grant_pulse_idle", 32'(grant_pulse), 32'd0);
      end
      if (tick_q.size() > 0) begin
        ef = tick_q.pop_front();
        chk("frame_tick", 32'(frame_tick), 32'd1);
        chk("tick_frame_count", 32'(frame_count), 32'(ef));
      end else begin
        chk("frame_tick_idle", 32'(frame_tick), 32'd0);
      end
    end
  end

  task automatic cyc(input logic [9:0] py, input logic [NB-1:0] hr);
    pixel_y = py;
    hit_req = hr;
    @(posedge clk_25);
    if (rst === 1'b1) model_edge(py, hr);
    #1;
  endtask

  task automatic drive(input bit vbl, input int hit_pct, input bit collide);
    logic [NB-1:0] hr;
    logic [9:0] py;
    int pk;
    py = vbl ? 10'($urandom_range(VA, 1023)) : 10'($urandom_range(0, VA - 1));
    hr = ($urandom_range(0, 99) < hit_pct) ? NB'($urandom) : '0;
    pk = m_pick();
    if (collide && (edge_no + 1 == grant_edge) && pk >= 0) hr = hr | (NB'(1) << pk);
    cyc(py, hr);
  endtask

  task automatic run_frames(input int n, input int hit_pct, input bit collide);
    for (int f = 0; f < n; f++) begin
      int vl, bl;
      vl = $urandom_range(1, 5);
      bl = $urandom_range(1, 5);
      for (int c = 0; c < vl; c++) drive(1'b0, hit_pct, collide);
      for (int c = 0; c < bl; c++) drive(1'b1, hit_pct, collide);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bar_active"}, 32'(bar_active), 32'd0);
    chk({tag, "_grant_pulse"}, 32'(grant_pulse), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    pixel_y = 10'd0;
    hit_req = '0;
    model_reset();
    #2 rst = 1'b0;
    #70;
    chk_reset_outputs("reset");
    @(posedge clk_25);
    #10 rst = 1'b1;

    // Single hit on bar 2, then let the flash run out.
    cyc(10'd100, 8'h04);
    run_frames(33, 0, 1'b0);

    // All bars at once, then a late re-hit on bar 0 during the rotation.
    cyc(10'd100, 8'hFF);
    run_frames(3, 0, 1'b0);
    cyc(10'd100, 8'h01);
    run_frames(10, 0, 1'b0);

    // Retrigger bar 5 while still active.
    run_frames(32, 0, 1'b0);
    cyc(10'd100, 8'h20);
    run_frames(20, 0, 1'b0);
    cyc(10'd100, 8'h20);
    run_frames(6, 0, 1'b0);

    // Hit on the bar being granted in the very grant cycle.
    cyc(10'd100, 8'h01);
    run_frames(4, 0, 1'b1);

    // Frame counter wrap.
    force dut.frame_cnt = 20'hFFFFE;
    #1 release dut.frame_cnt;
    m_fc = 20'hFFFFE;
    run_frames(3, 0, 1'b0);

    // Random traffic with random region lengths and occasional collisions.
    run_frames(80, 30, 1'b0);
    run_frames(80, 40, 1'b1);

    // Asynchronous reset mid-flash, released inside vblank.
    run_frames(45, 0, 1'b0);
    cyc(10'd100, 8'h0A);
    run_frames(4, 0, 1'b0);
    chk("pre_reset_active", 32'(bar_active), 32'h0A);
    cyc(10'd500, 8'h00);
    #5 rst = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    cyc(10'd600, 8'h00);
    cyc(10'd600, 8'h00);
    #5 rst = 1'b1;
    for (int c = 0; c < 6; c++) drive(1'b1, 0, 1'b0);
    run_frames(4, 20, 1'b0);

    #50;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
